// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-lane TDM demultiplexer.
// The master side drives the serial beat stream.
// The slave side (the demux) returns the reassembled frame and its status.
interface tdm_demux4_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic               in_valid;
    logic               sof;
    logic [WIDTH-1:0]   din;
    logic [4*WIDTH-1:0] dout;
    logic               frame_valid;
    logic               sync_err;
    logic [1:0]         slot;
    logic [CNT_W-1:0]   frame_cnt;

    modport master (
        output in_valid, sof, din,
        input  dout, frame_valid, sync_err, slot, frame_cnt
    );

    modport slave (
        input  in_valid, sof, din,
        output dout, frame_valid, sync_err, slot, frame_cnt
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer.
// Tracks the slot index from a start-of-frame marker, gathers slots 0..2 in
// shadow lanes, and on the slot-3 beat publishes the whole frame on dout
// with a one-cycle frame_valid strobe. A sof arriving mid-frame discards
// the partial frame, pulses sync_err, and starts a new frame from that beat.
module tdm_demux4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           slot_q, slot_d;
    logic [WIDTH-1:0]     shadow_q [3];
    logic [WIDTH-1:0]     shadow_d [3];
    logic [4*WIDTH-1:0]   dout_q, dout_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

    // State register: async active-low reset clears the FSM, lanes and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            shadow_q[0]   <= '0;
            shadow_q[1]   <= '0;
            shadow_q[2]   <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q[0]   <= shadow_d[0];
            shadow_q[1]   <= shadow_d[1];
            shadow_q[2]   <= shadow_d[2];
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Next-state logic: hold everything by default, strobes default low.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d[0]   = shadow_q[0];
        shadow_d[1]   = shadow_q[1];
        shadow_d[2]   = shadow_q[2];
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            IDLE: begin
                // Beats without sof are dropped while hunting for a frame start.
                if (bus.in_valid && bus.sof) begin
                    shadow_d[0] = bus.din;
                    slot_d      = 2'd1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    if (bus.sof) begin
                        // Premature sof: drop the partial frame, restart at slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        dout_d        = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                        slot_d        = 2'd0;
                        state_d       = IDLE;
                    end else begin
                        if (slot_q == 2'd1) begin
                            shadow_d[1] = bus.din;
                        end else begin
                            shadow_d[2] = bus.din;
                        end
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = 2'd0;
            end
        endcase
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.slot        = slot_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4 (WIDTH=4, CNT_W=2 so the frame counter wraps quickly).
// A frame-level reference model (a queue of collected lanes) predicts every output.
module tb_tdm_demux4;

    localparam int W  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    tdm_demux4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: lanes gathered so far in the current frame.
    logic [W-1:0]   partial [$];
    logic [4*W-1:0] mDout;
    logic           mFv;
    logic           mSe;
    logic [CW-1:0]  mCnt;

    function automatic logic [1:0] mSlot();
        return 2'(partial.size());
    endfunction

    task automatic modelReset();
        partial.delete();
        mDout = '0;
        mFv   = 1'b0;
        mSe   = 1'b0;
        mCnt  = '0;
    endtask

    task automatic modelBeat(input logic v, input logic s, input logic [W-1:0] d);
        mFv = 1'b0;
        mSe = 1'b0;
        if (v) begin
            if (s) begin
                if (partial.size() != 0) mSe = 1'b1;
                partial.delete();
                partial.push_back(d);
            end else if (partial.size() != 0) begin
                partial.push_back(d);
                if (partial.size() == 4) begin
                    mDout = {partial[3], partial[2], partial[1], partial[0]};
                    mFv   = 1'b1;
                    mCnt  = mCnt + 1'b1;
                    partial.delete();
                end
            end
        end
    endtask

    // Drive one cycle at the falling edge, advance the model, settle past the rising edge.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.sof      = s;
        bus.din      = d;
        @(posedge clk);
        modelBeat(v, s, d);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        bus.din      = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        modelReset();
        #1;
        total++;
        if ({bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_state: got dout=%h fv=%b se=%b slot=%0d cnt=%0d want all zero",
                     bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] lanes [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [1:0]   slots [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, lanes[i]);
            total++;
            if ({bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt} !==
                {mDout, mFv, mSe, slots[i], mCnt}) begin
                bad++;
                $display("FAIL basic_beat%0d: got dout=%h fv=%b se=%b slot=%0d cnt=%0d want dout=%h fv=%b se=%b slot=%0d cnt=%0d",
                         i, bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt,
                         mDout, mFv, mSe, slots[i], mCnt);
            end
        end
        total++;
        if ({bus.dout, bus.frame_valid, bus.frame_cnt} !== {16'h1010, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL basic_frame: got dout=%h fv=%b cnt=%0d want dout=1010 fv=1 cnt=1",
                     bus.dout, bus.frame_valid, bus.frame_cnt);
        end
        step(1'b0, 1'b0, '0);
        total++;
        if ({bus.dout, bus.frame_valid} !== {16'h1010, 1'b0}) begin
            bad++;
            $display("FAIL basic_pulse_end: got dout=%h fv=%b want dout=1010 fv=0",
                     bus.dout, bus.frame_valid);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] lanes [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, lanes[i]);
            if (bus.frame_valid) pulses++;
            for (int g = 0; g < 3 && i < 3; g++) begin
                step(1'b0, 1'b0, 4'hF);
                if (bus.frame_valid) pulses++;
                total++;
                if ({bus.slot, bus.frame_valid, bus.sync_err} !== {mSlot(), 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL gap_hold%0d_%0d: got slot=%0d fv=%b se=%b want slot=%0d fv=0 se=0",
                             i, g, bus.slot, bus.frame_valid, bus.sync_err, mSlot());
                end
            end
        end
        step(1'b0, 1'b0, '0);
        total++;
        if ({bus.dout, 8'(pulses), bus.frame_cnt} !== {mDout, 8'd1, mCnt}) begin
            bad++;
            $display("FAIL gap_frame: got dout=%h pulses=%0d cnt=%0d want dout=%h pulses=1 cnt=%0d",
                     bus.dout, pulses, bus.frame_cnt, mDout, mCnt);
        end
    endtask

    task automatic test_sync_err();
        logic [W-1:0] lanes [6] = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1};
        logic         sofs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [CW-1:0] cntBefore = mCnt;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, sofs[i], lanes[i]);
            total++;
            if ({bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt} !==
                {mDout, mFv, mSe, mSlot(), mCnt}) begin
                bad++;
                $display("FAIL sync_beat%0d: got dout=%h fv=%b se=%b slot=%0d cnt=%0d want dout=%h fv=%b se=%b slot=%0d cnt=%0d",
                         i, bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt,
                         mDout, mFv, mSe, mSlot(), mCnt);
            end
            if (i == 2) begin
                total++;
                if (bus.sync_err !== 1'b1) begin
                    bad++;
                    $display("FAIL sync_pulse: got se=%b want 1", bus.sync_err);
                end
            end
        end
        total++;
        if ({bus.dout, bus.frame_cnt} !== {16'h1110, CW'(cntBefore + 1'b1)}) begin
            bad++;
            $display("FAIL sync_frame: got dout=%h cnt=%0d want dout=1110 cnt=%0d",
                     bus.dout, bus.frame_cnt, CW'(cntBefore + 1'b1));
        end
    endtask

    task automatic test_idle_drop();
        logic [W-1:0] lanes [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'(i + 3));
            total++;
            if ({bus.frame_valid, bus.sync_err, bus.slot} !== 4'b0000) begin
                bad++;
                $display("FAIL idle_drop%0d: got fv=%b se=%b slot=%0d want fv=0 se=0 slot=0",
                         i, bus.frame_valid, bus.sync_err, bus.slot);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, lanes[i]);
        total++;
        if ({bus.dout, bus.frame_valid, bus.frame_cnt} !== {16'h0011, 1'b1, mCnt}) begin
            bad++;
            $display("FAIL idle_frame: got dout=%h fv=%b cnt=%0d want dout=0011 fv=1 cnt=%0d",
                     bus.dout, bus.frame_valid, bus.frame_cnt, mCnt);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] lanes [4] = '{4'd1, 4'd0, 4'd0, 4'd1};
        step(1'b1, 1'b1, 4'd7);
        step(1'b1, 1'b0, 4'd5);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        total++;
        if ({bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset: got dout=%h fv=%b se=%b slot=%0d cnt=%0d want all zero",
                     bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, lanes[i]);
        total++;
        if ({bus.dout, bus.frame_valid, bus.frame_cnt} !== {16'h1001, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL reset_frame: got dout=%h fv=%b cnt=%0d want dout=1001 fv=1 cnt=1",
                     bus.dout, bus.frame_valid, bus.frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  lanes [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [CW-1:0] cnts  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int pulseCycle [$];
        applyReset();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, i == 0, lanes[i]);
                if (bus.frame_valid) pulseCycle.push_back(f * 4 + i);
            end
            total++;
            if ({bus.dout, bus.frame_valid, bus.frame_cnt} !== {16'hDCBA, 1'b1, cnts[f]}) begin
                bad++;
                $display("FAIL b2b_frame%0d: got dout=%h fv=%b cnt=%0d want dout=dcba fv=1 cnt=%0d",
                         f, bus.dout, bus.frame_valid, bus.frame_cnt, cnts[f]);
            end
        end
        total++;
        if (pulseCycle.size() != 5) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d pulses want 5", pulseCycle.size());
        end else begin
            for (int p = 1; p < 5; p++) begin
                total++;
                if (pulseCycle[p] - pulseCycle[p-1] != 4) begin
                    bad++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles want 4",
                             p, pulseCycle[p] - pulseCycle[p-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic v, s;
        logic [W-1:0] d;
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 3) == 0);
            d = W'($urandom);
            step(v, s, d);
            total++;
            if ({bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt} !==
                {mDout, mFv, mSe, mSlot(), mCnt}) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random%0d: got dout=%h fv=%b se=%b slot=%0d cnt=%0d want dout=%h fv=%b se=%b slot=%0d cnt=%0d",
                             i, bus.dout, bus.frame_valid, bus.sync_err, bus.slot, bus.frame_cnt,
                             mDout, mFv, mSe, mSlot(), mCnt);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_sync_err();
        test_idle_drop();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Receive-side counterpart of the team's 4:1 mux. It takes a time-division-multiplexed stream that a 4:1 mux produces by stepping its select through 00, 01, 10, 11, and reassembles it into four parallel lanes. It tracks the slot index internally from a start-of-frame marker, buffers the lanes, and presents each complete frame with a one-cycle valid strobe. It sits between a serial link or shared wire and the downstream parallel logic.

Parameters:
WIDTH, 1, bit width of each lane and of din
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  din/sof qualify this cycle (a beat)
sof  input  1  beat carries slot 0 of a new frame; ignored when in_valid=0
din  input  WIDTH  serial lane data for the current slot
dout  output  4*WIDTH  reassembled frame; lane k at dout[k*WIDTH +: WIDTH] (lane 0 = slot 0 = mux sel 00)
frame_valid  output  1  one-cycle pulse: dout holds a new complete frame
sync_err  output  1  one-cycle pulse: sof arrived mid-frame, frame discarded
slot  output  2  slot index expected for the next beat (mirrors the mux sel)
frame_cnt  output  CNT_W  completed frames since reset, wraps

Behaviour:
- Reset (rst_n=0, async assert, sync release): state=IDLE, slot=0, shadow lanes 0..2=0, dout=0, frame_valid=0, sync_err=0, frame_cnt=0. Reset mid-frame discards the partial frame with no frame_valid.
- State machine: IDLE (waiting for sof) and RUN (collecting slots 1..3).
- IDLE:
  - in_valid & sof -> shadow[0]<=din, slot<=1, go RUN.
  - in_valid & !sof -> beat dropped, no flags, stay IDLE, slot stays 0.
  - in_valid=0 -> hold.
- RUN, in_valid=0: hold all state. Gaps of any length are allowed; there is no timeout.
- RUN, in_valid & !sof, slot=1 or 2 -> shadow[slot]<=din, slot<=slot+1.
- RUN, in_valid & !sof, slot=3 -> on the same edge:
  - dout<={din, shadow[2], shadow[1], shadow[0]}
  - frame_valid<=1
  - frame_cnt<=frame_cnt+1 (mod 2^CNT_W)
  - slot<=0, go IDLE
- Latency: dout/frame_valid are visible in the cycle after the slot-3 beat is sampled.
- frame_valid and sync_err are high for exactly one cycle each. dout holds its value until the next completed frame.
- RUN, in_valid & sof (premature sof, any slot 1..3):
  - sync_err<=1 for one cycle
  - partial frame discarded; dout, frame_valid and frame_cnt unchanged
  - the sof beat is the new slot 0: shadow[0]<=din, slot<=1, stay RUN
- Back-to-back frames: a slot-0 sof beat in the cycle right after a slot-3 beat is accepted normally (state is IDLE). There are zero dead cycles between frames.
- No backpressure: every in_valid beat is consumed. The downstream must capture dout on frame_valid or before the next frame completes.
- Shadow lanes 1..2 are not cleared between frames; they are always overwritten before use.

Test Plan:
1. WIDTH=1, beats (sof=1,din=0),(1),(0),(1) on consecutive cycles -> one cycle later dout=4'b1010, frame_valid=1 for 1 cycle, frame_cnt=1, slot sequence 1,2,3,0.
2. Same frame with in_valid low for 3 cycles between each beat -> identical dout=4'b1010, a single frame_valid, slot holds during the gaps.
3. Beats sof,din=1 then 1, then a premature sof with din=0, then 1,1,1 -> sync_err pulse one cycle after the third beat, then dout=4'b1110, frame_cnt increments by exactly 1.
4. In IDLE, send 5 beats with sof=0 -> no frame_valid, no sync_err, slot=0. Then a normal frame 1,1,0,0 -> dout=4'b0011.
5. Assert rst_n=0 asynchronously after 2 beats of a frame -> all outputs 0 immediately. After release, a full frame 1,0,0,1 -> dout=4'b1001, frame_cnt=1.
6. WIDTH=4, CNT_W=2, 5 back-to-back frames with lanes A,B,C,D -> dout=16'hDCBA on each frame_valid, five pulses spaced 4 cycles apart, frame_cnt sequence 1,2,3,0,1.
